// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return sequencing for a single-hart core.
// Reads are combinational; traps, mret and CSR writes are arbitrated per cycle.
module csr_trap_unit #(
  parameter int unsigned CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic [31:0] pc,
  input  logic        instr_retire,
  input  logic        is_ecall,
  input  logic        is_ebreak,
  input  logic        is_mret,
  input  logic        irq_timer,
  output logic        trap_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam int unsigned HI_W = CNT_WIDTH - 32;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  // Mode 1 survives only when vectored mode is enabled; modes 2/3 collapse to direct.
  function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
    logic [1:0] mode;
    mode = (v[1:0] == 2'b01 && VECTORED_EN) ? 2'b01 : 2'b00;
    return {v[31:2], mode};
  endfunction

  logic                 mstatus_mie_q, mstatus_mie_d;
  logic                 mstatus_mpie_q, mstatus_mpie_d;
  logic                 mie_mtie_q, mie_mtie_d;
  logic [31:0]          mtvec_q, mtvec_d;
  logic [31:0]          mscratch_q, mscratch_d;
  logic [31:0]          mepc_q, mepc_d;
  logic [31:0]          mcause_q, mcause_d;
  logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
  logic [CNT_WIDTH-1:0] minstret_q, minstret_d;

  logic [63:0] mcycle_ext, minstret_ext;
  logic [31:0] mstatus_rd, wval, tvec_base;
  logic        known, read_only;
  logic        exc_evt, int_pending;
  logic        take_exc, take_int, take_mret, csr_we;

  assign mcycle_ext   = 64'(mcycle_q);
  assign minstret_ext = 64'(minstret_q);
  assign mstatus_rd   = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign tvec_base    = {mtvec_q[31:2], 2'b00};

  always_comb begin
    csr_rdata = 32'h0;
    known     = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      12'h300: csr_rdata = mstatus_rd;
      12'h304: csr_rdata = {24'b0, mie_mtie_q, 7'b0};
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h344: csr_rdata = {24'b0, irq_timer, 7'b0};
      12'hB00: csr_rdata = mcycle_ext[31:0];
      12'hB02: csr_rdata = minstret_ext[31:0];
      12'hB80: csr_rdata = mcycle_ext[63:32];
      12'hB82: csr_rdata = minstret_ext[63:32];
      12'hF11: begin csr_rdata = 32'h79737978; read_only = 1'b1; end
      12'hF12: begin csr_rdata = 32'h26964ECE; read_only = 1'b1; end
      12'hF14: begin csr_rdata = 32'h0;        read_only = 1'b1; end
      default: known = 1'b0;
    endcase
  end

  assign csr_illegal = ~rst & (~known | ((csr_op != 2'b00) & read_only));

  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = csr_rdata | csr_wdata;
      2'b11:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  // Arbitration: exception > interrupt > mret > CSR write; reset silences everything.
  assign exc_evt     = is_ecall | is_ebreak;
  assign int_pending = mstatus_mie_q & mie_mtie_q & irq_timer;
  assign take_exc    = ~rst & exc_evt;
  assign take_int    = ~rst & ~exc_evt & int_pending;
  assign take_mret   = ~rst & ~exc_evt & ~int_pending & is_mret;
  assign csr_we      = ~rst & ~exc_evt & ~int_pending & ~is_mret
                       & (csr_op != 2'b00) & ~csr_illegal;

  assign trap_taken = take_exc | take_int;
  assign redirect   = trap_taken | take_mret;

  always_comb begin
    if (take_exc)
      redirect_pc = tvec_base;
    else if (take_int)
      redirect_pc = (mtvec_q[1:0] == 2'b01) ? tvec_base + 32'd28 : tvec_base;
    else if (take_mret)
      redirect_pc = mepc_q;
    else
      redirect_pc = 32'h0;
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + CNT_ONE;
    minstret_d     = minstret_q + ((instr_retire && !trap_taken) ? CNT_ONE : CNT_ZERO);
    if (take_exc || take_int) begin
      mepc_d         = pc & 32'hFFFF_FFFC;
      mcause_d       = take_int ? 32'h8000_0007 : (is_ecall ? 32'd11 : 32'd3);
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        12'h304: mie_mtie_d = wval[7];
        12'h305: mtvec_d    = legal_mtvec(wval);
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval & 32'hFFFF_FFFC;
        12'h342: mcause_d   = wval;
        // A write to either counter half replaces this cycle's increment.
        12'hB00: mcycle_d   = {mcycle_q[CNT_WIDTH-1:32], wval};
        12'hB80: mcycle_d   = {wval[HI_W-1:0], mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[CNT_WIDTH-1:32], wval};
        12'hB82: minstret_d = {wval[HI_W-1:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= legal_mtvec(MTVEC_RESET);
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit (33-bit counters, vectored mtvec reset value):
// directed scenarios plus a random run against a behavioural machine-mode model.
module tb_csr_trap_unit;

  localparam longint unsigned CMASK = 64'h1_FFFF_FFFF;

  logic        clk, rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata, pc, redirect_pc;
  logic        csr_illegal, instr_retire, is_ecall, is_ebreak, is_mret, irq_timer;
  logic        trap_taken, redirect;

  int checks = 0;
  int errors = 0;

  csr_trap_unit #(.CNT_WIDTH(33), .MTVEC_RESET(32'h0000_2001), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .pc(pc), .instr_retire(instr_retire),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .irq_timer(irq_timer),
    .trap_taken(trap_taken), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural state of the model
  bit              m_mie, m_mpie, m_mtie;
  logic [31:0]     m_mtvec, m_mscratch, m_mepc, m_mcause;
  longint unsigned m_cyc, m_ret;
  logic [31:0]     e_rdata, e_rpc;
  bit              e_illegal, e_trap, e_redirect;

  function automatic bit m_known(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                     12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 0) + (m_mie ? 32'h8 : 0);
      12'h304: return m_mtie ? 32'h80 : 32'h0;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return irq_timer ? 32'h80 : 32'h0;
      12'hB00: return 32'(m_cyc);
      12'hB80: return 32'(m_cyc >> 32);
      12'hB02: return 32'(m_ret);
      12'hB82: return 32'(m_ret >> 32);
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h26964ECE;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_expect();
    bit exc, intp;
    exc  = is_ecall || is_ebreak;
    intp = m_mie && m_mtie && irq_timer;
    e_rdata    = m_read(csr_addr);
    e_illegal  = !rst && (!m_known(csr_addr) ||
                 (csr_op != 0 && csr_addr inside {12'hF11, 12'hF12, 12'hF14}));
    e_trap     = !rst && (exc || intp);
    e_redirect = !rst && (exc || intp || is_mret);
    if (rst)       e_rpc = 0;
    else if (exc)  e_rpc = (m_mtvec / 4) * 4;
    else if (intp) e_rpc = (m_mtvec / 4) * 4 + ((m_mtvec % 4 == 1) ? 28 : 0);
    else if (is_mret) e_rpc = m_mepc;
    else           e_rpc = 0;
  endtask

  task automatic model_commit();
    bit exc, intp, cyc_w, ret_w;
    logic [31:0] old, nv;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_mtie = 0; m_mtvec = 32'h2001;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ret = 0;
      return;
    end
    model_expect();
    exc  = is_ecall || is_ebreak;
    intp = m_mie && m_mtie && irq_timer;
    old  = m_read(csr_addr);
    nv   = (csr_op == 1) ? csr_wdata : (csr_op == 2) ? (old | csr_wdata) : (old & ~csr_wdata);
    cyc_w = 0; ret_w = 0;
    if (exc || intp) begin
      m_mepc   = (pc / 4) * 4;
      m_mcause = intp && !exc ? 32'h8000_0007 : (is_ecall ? 32'd11 : 32'd3);
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (is_mret) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (csr_op != 0 && !e_illegal) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mtie = nv[7];
        12'h305: m_mtvec = (nv / 4) * 4 + ((nv % 4 == 1) ? 1 : 0);
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = (nv / 4) * 4;
        12'h342: m_mcause = nv;
        12'hB00: begin m_cyc = ((m_cyc >> 32) << 32) + nv; cyc_w = 1; end
        12'hB80: begin m_cyc = ((longint'(nv) << 32) & CMASK) + (m_cyc % 64'h1_0000_0000); cyc_w = 1; end
        12'hB02: begin m_ret = ((m_ret >> 32) << 32) + nv; ret_w = 1; end
        12'hB82: begin m_ret = ((longint'(nv) << 32) & CMASK) + (m_ret % 64'h1_0000_0000); ret_w = 1; end
        default: ;
      endcase
    end
    if (!cyc_w) m_cyc = (m_cyc + 1) & CMASK;
    if (!ret_w && instr_retire && !(exc || intp)) m_ret = (m_ret + 1) & CMASK;
  endtask

  task automatic idle();
    csr_addr = 0; csr_op = 0; csr_wdata = 0; pc = 0; instr_retire = 0;
    is_ecall = 0; is_ebreak = 0; is_mret = 0; irq_timer = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
    idle();
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
    csr_op = op; csr_addr = a; csr_wdata = w;
  endtask

  task automatic test_reset();
    rst = 1; csr(2'b01, 12'h7C0, 32'hFFFF); is_ecall = 1; irq_timer = 1;
    @(negedge clk);
    checks++;
    if (trap_taken !== 0 || redirect !== 0 || redirect_pc !== 0 || csr_illegal !== 0) begin
      errors++;
      $display("FAIL reset_outputs got trap=%b redir=%b pc=%h ill=%b exp all 0",
               trap_taken, redirect, redirect_pc, csr_illegal);
    end
    tick();
    rst = 1; csr(2'b01, 12'h340, 32'h1234);
    tick();
    rst = 0; csr_addr = 12'h300;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp 00001800", csr_rdata); end
    tick();
    csr_addr = 12'hB00;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1) begin errors++; $display("FAIL reset_mcycle got %h exp 00000001", csr_rdata); end
    tick();
    csr_addr = 12'h305;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h2001) begin errors++; $display("FAIL reset_mtvec got %h exp 00002001", csr_rdata); end
    tick();
    csr_addr = 12'hF11;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h79737978) begin errors++; $display("FAIL reset_mvendorid got %h exp 79737978", csr_rdata); end
    tick();
    csr_addr = 12'h340;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mscratch got %h exp 0", csr_rdata); end
    tick();
  endtask

  task automatic test_exception();
    csr(2'b01, 12'h305, 32'h8000_0001);
    tick();
    is_ecall = 1; pc = 32'h100;
    @(negedge clk);
    checks++;
    if (trap_taken !== 1 || redirect !== 1 || redirect_pc !== 32'h8000_0000) begin
      errors++;
      $display("FAIL ecall_entry got trap=%b redir=%b pc=%h exp 1 1 80000000", trap_taken, redirect, redirect_pc);
    end
    tick();
    csr_addr = 12'h341;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h100) begin errors++; $display("FAIL ecall_mepc got %h exp 00000100", csr_rdata); end
    tick();
    csr_addr = 12'h342;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'd11) begin errors++; $display("FAIL ecall_mcause got %h exp 0000000b", csr_rdata); end
    tick();
  endtask

  task automatic test_interrupt();
    csr(2'b10, 12'h300, 32'h8);
    tick();
    csr(2'b10, 12'h304, 32'h80);
    tick();
    irq_timer = 1; pc = 32'h204; csr_addr = 12'h300;
    @(negedge clk);
    checks++;
    if (trap_taken !== 1 || redirect_pc !== 32'h8000_001C || csr_rdata !== 32'h1808) begin
      errors++;
      $display("FAIL irq_entry got trap=%b pc=%h rdata=%h exp 1 8000001c 00001808", trap_taken, redirect_pc, csr_rdata);
    end
    tick();
    csr_addr = 12'h342;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL irq_mcause got %h exp 80000007", csr_rdata); end
    tick();
    csr_addr = 12'h300;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL irq_mstatus got %h exp 00001880", csr_rdata); end
    tick();
    is_mret = 1; csr_addr = 12'h341;
    @(negedge clk);
    checks++;
    if (redirect !== 1 || trap_taken !== 0 || redirect_pc !== 32'h204 || csr_rdata !== 32'h204) begin
      errors++;
      $display("FAIL mret got redir=%b trap=%b pc=%h mepc=%h exp 1 0 00000204 00000204",
               redirect, trap_taken, redirect_pc, csr_rdata);
    end
    tick();
    csr_addr = 12'h300;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp 00001888", csr_rdata); end
    tick();
  endtask

  task automatic test_csr_ops();
    csr(2'b01, 12'h300, 32'h0);
    tick();
    csr(2'b10, 12'h300, 32'hFFFF_FFFF);
    tick();
    csr_addr = 12'h300;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL rs_mstatus got %h exp 00001888", csr_rdata); end
    tick();
    csr(2'b11, 12'h300, 32'h8);
    tick();
    csr_addr = 12'h300;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL rc_mstatus got %h exp 00001880", csr_rdata); end
    tick();
    csr(2'b01, 12'hF12, 32'h0);
    @(negedge clk);
    checks++;
    if (csr_illegal !== 1) begin errors++; $display("FAIL ro_write_illegal got %b exp 1", csr_illegal); end
    tick();
    csr_addr = 12'hF12;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h26964ECE || csr_illegal !== 0) begin
      errors++; $display("FAIL marchid_read got %h ill=%b exp 26964ece 0", csr_rdata, csr_illegal);
    end
    tick();
    csr_addr = 12'h123;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 0 || csr_illegal !== 1) begin
      errors++; $display("FAIL unimpl_read got %h ill=%b exp 0 1", csr_rdata, csr_illegal);
    end
    tick();
    csr(2'b01, 12'h344, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (csr_illegal !== 0) begin errors++; $display("FAIL mip_write_illegal got %b exp 0", csr_illegal); end
    tick();
    csr(2'b01, 12'h341, 32'h103);
    tick();
    csr_addr = 12'h341;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h100) begin errors++; $display("FAIL mepc_align got %h exp 00000100", csr_rdata); end
    tick();
    csr(2'b01, 12'h305, 32'h8000_0002);
    tick();
    csr_addr = 12'h305;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_mode2 got %h exp 80000000", csr_rdata); end
    tick();
  endtask

  task automatic test_counter_wrap();
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick();
    csr(2'b01, 12'hB80, 32'h1);
    tick();
    csr_addr = 12'hB80;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycleh_top got %h exp 00000001", csr_rdata); end
    tick();
    csr_addr = 12'hB00;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got %h exp 0", csr_rdata); end
    tick();
    csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
    tick();
    csr_addr = 12'hB80;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1) begin errors++; $display("FAIL mcycleh_mask got %h exp 00000001", csr_rdata); end
    tick();
    csr(2'b01, 12'hB02, 32'hFFFF_FFFF); instr_retire = 1;
    tick();
    csr(2'b01, 12'hB82, 32'h1); instr_retire = 1;
    tick();
    csr_addr = 12'hB82; instr_retire = 1;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h1) begin errors++; $display("FAIL minstreth_top got %h exp 00000001", csr_rdata); end
    tick();
    csr_addr = 12'hB02;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL minstret_wrap got %h exp 0", csr_rdata); end
    tick();
  endtask

  task automatic test_priority();
    csr(2'b01, 12'h340, 32'h5A5A);
    tick();
    csr(2'b10, 12'h300, 32'h8);
    tick();
    is_ecall = 1; is_mret = 1; irq_timer = 1; instr_retire = 1; pc = 32'h300;
    csr(2'b01, 12'h340, 32'hFFFF);
    @(negedge clk);
    checks++;
    if (trap_taken !== 1 || redirect !== 1 || redirect_pc !== 32'h8000_0000 || csr_rdata !== 32'h5A5A) begin
      errors++;
      $display("FAIL prio_entry got trap=%b redir=%b pc=%h rdata=%h exp 1 1 80000000 00005a5a",
               trap_taken, redirect, redirect_pc, csr_rdata);
    end
    tick();
    csr_addr = 12'h340;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h5A5A) begin errors++; $display("FAIL prio_mscratch got %h exp 00005a5a", csr_rdata); end
    tick();
    csr_addr = 12'h342;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'd11) begin errors++; $display("FAIL prio_mcause got %h exp 0000000b", csr_rdata); end
    tick();
    csr_addr = 12'hB02;
    @(negedge clk);
    checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL prio_minstret got %h exp 0", csr_rdata); end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] addrs [14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                                12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12, 12'hF14};
    int sel;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      sel = $urandom_range(0, 15);
      csr_addr     = (sel < 14) ? addrs[sel] : 12'($urandom);
      csr_op       = 2'($urandom_range(0, 3));
      csr_wdata    = $urandom;
      pc           = $urandom;
      instr_retire = 1'($urandom_range(0, 1));
      is_ecall     = ($urandom_range(0, 15) == 0);
      is_ebreak    = ($urandom_range(0, 15) == 0);
      is_mret      = ($urandom_range(0, 7) == 0);
      irq_timer    = 1'($urandom_range(0, 1));
      @(negedge clk);
      model_expect();
      checks++;
      if (trap_taken !== e_trap || redirect !== e_redirect || redirect_pc !== e_rpc || csr_illegal !== e_illegal) begin
        errors++;
        $display("FAIL rand_ctrl it %0d got trap=%b redir=%b pc=%h ill=%b exp %b %b %h %b",
                 i, trap_taken, redirect, redirect_pc, csr_illegal, e_trap, e_redirect, e_rpc, e_illegal);
      end
      if (!rst) begin
        checks++;
        if (csr_rdata !== e_rdata) begin
          errors++;
          $display("FAIL rand_rdata it %0d addr %h got %h exp %h", i, csr_addr, csr_rdata, e_rdata);
        end
      end
      @(posedge clk);
      model_commit();
      #1;
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_exception();
    test_interrupt();
    test_csr_ops();
    test_counter_wrap();
    test_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
